timestamper_pulses_ctrl: RTL
============================

TIMESTAMPER_PULSES_CTRL -- requirements
Module: timestamper_pulses_ctrl

Interface
REQ-001 Parameter C_BASEADDR, default 32'h01000000, first byte address of the register window.
REQ-002 Parameter C_HIGHADDR, default 32'h010000FF, last byte address of the register window.
REQ-003 Parameter C_ADDR_W, default 10, width of the pulse buffer word address.
REQ-004 OPB_Clk  in  1  single clock for all logic.
REQ-005 OPB_Rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-006 OPB_ABus  in  [0:31]  OPB address; bit 31 is the LSB.
REQ-007 OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31].
REQ-008 OPB_DBus  in  [0:31]  write data.
REQ-009 OPB_RNW  in  1  1 = read, 0 = write.
REQ-010 OPB_select  in  1  transfer request.
REQ-011 OPB_seqAddr  in  1  ignored.
REQ-012 Sl_DBus  out  [0:31]  read data; 0 whenever Sl_xferAck = 0.
REQ-013 Sl_xferAck  out  1  one-cycle transfer acknowledge.
REQ-014 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
REQ-015 pulse_valid  in  1  one timestamped pulse word is presented this cycle.
REQ-016 pulse_data  in  32  pulse word.
REQ-017 buf_we  out  1  buffer write strobe.
REQ-018 buf_addr  out  C_ADDR_W  buffer write address.
REQ-019 buf_data  out  32  buffer write data.

Function
REQ-020 Address decode: hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; register index = OPB_ABus[28:29].
REQ-021 Bus FSM has three states: IDLE, ACK, HOLD.
- IDLE -> ACK on hit.
- ACK -> HOLD unconditionally; Sl_xferAck = 1 for exactly this one cycle.
- HOLD -> IDLE when OPB_select = 0.
REQ-022 The register access is performed in the ACK cycle, so latency from first select to ack is 1 cycle; no second ack is issued until select has been low for at least 1 cycle.
REQ-023 Register map (byte offsets; bits are LSB-numbered as value bits):
- 0x00 CTRL, RW: bit0 = run, bit1 = clear (write-1, self-clearing, reads 0).
- 0x04 ADDR, RO: bit31 = wrap toggle; bits C_ADDR_W-1:0 = next write address.
- 0x08 COUNT, RO: 32-bit count of accepted pulses, wraps modulo 2^32.
- 0x0C DROP, RO: 32-bit count of pulses arriving while run = 0, saturating at FFFFFFFF.
REQ-024 A CTRL write takes effect only when OPB_BE[3] = 1; all other writes are acked and have no effect.
REQ-025 Reads of unused bits return 0.
REQ-026 Pulse accept: when pulse_valid = 1, run = 1 and no clear is occurring this cycle, the next cycle drives buf_we = 1, buf_data = pulse_data and buf_addr = the pre-increment address; the address then increments and COUNT increments (1-cycle pipeline).
REQ-027 Wrap: when the address increments from 2^C_ADDR_W-1 it goes to 0 and the wrap toggle inverts.
REQ-028 Drop: pulse_valid = 1 with run = 0 increments DROP and produces no buf_we.
REQ-029 Clear takes effect in the cycle after the write ack and zeroes address, wrap, COUNT and DROP. A pulse arriving in the same cycle is dropped and not counted; the run bit is unchanged.
REQ-030 A register read returns the value held at the start of the ACK cycle. An update in the same cycle becomes visible on the next read.
REQ-031 buf_we is never asserted while reset is active, nor in the cycle immediately after reset release.

Reset
REQ-032 With OPB_Rst = 0 at a rising edge:
- FSM goes to IDLE.
- Sl_xferAck = 0, Sl_DBus = 0, buf_we = 0, buf_addr = 0, buf_data = 0.
- run = 0, wrap = 0, COUNT = 0, DROP = 0.
REQ-033 Reset asserted mid-transfer aborts it; no ack is issued for that transfer after reset release until select has been seen low.

Verification
REQ-034 Write CTRL = 1 at 0x01000000 -> Sl_xferAck high exactly 1 cycle, 1 cycle after select; readback = 00000001.
REQ-035 run = 1, 3 pulses with data A,B,C -> buf_we at addresses 0,1,2 with data A,B,C, each 1 cycle after its pulse; ADDR reads 00000003; COUNT reads 3.
REQ-036 C_ADDR_W = 10, 1025 pulses -> the last write is at address 0; ADDR reads 80000001.
REQ-037 run = 0, 5 pulses -> no buf_we; DROP reads 5; COUNT unchanged.
REQ-038 Write CTRL = 3 in the same cycle as a pulse -> the pulse is dropped; ADDR, COUNT and DROP read 0; run stays 1; the next pulse is written at address 0.
REQ-039 OPB_select held high for 4 cycles -> exactly 1 ack; address 0x01000100 -> no ack.

Source files
------------

// File: rtl/timestamper_pulses_ctrl.sv
// OPB slave that gates timestamped pulse words into a circular buffer and
// exposes run/clear control plus address, accepted-count and drop-count status.
module timestamper_pulses_ctrl #(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_00FF,
  parameter int          C_ADDR_W   = 10
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst,
  input  logic [31:0]         OPB_ABus,
  input  logic [3:0]          OPB_BE,
  input  logic [31:0]         OPB_DBus,
  input  logic                OPB_RNW,
  input  logic                OPB_select,
  input  logic                OPB_seqAddr,
  output logic [31:0]         Sl_DBus,
  output logic                Sl_xferAck,
  output logic                Sl_errAck,
  output logic                Sl_retry,
  output logic                Sl_toutSup,
  input  logic                pulse_valid,
  input  logic [31:0]         pulse_data,
  output logic                buf_we,
  output logic [C_ADDR_W-1:0] buf_addr,
  output logic [31:0]         buf_data
);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} bus_state_t;

  bus_state_t            state;
  logic                  ack_q;
  logic                  sel_block;
  logic                  run;
  logic                  wrap;
  logic [C_ADDR_W-1:0]   wr_addr;
  logic [31:0]           count;
  logic [31:0]           drop;
  logic [31:0]           rdata;
  logic [1:0]            reg_idx;
  logic                  hit;
  logic                  ctrl_wr;
  logic                  clear_now;
  logic                  accept;
  logic                  dropped;
  logic                  unused_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Buses are OPB big-endian numbered; held here as plain value bits (bit 0 = LSB).
  assign reg_idx   = OPB_ABus[3:2];
  assign hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign ctrl_wr   = ack_q && !OPB_RNW && (reg_idx == 2'd0) && OPB_BE[0];
  assign clear_now = ctrl_wr && OPB_DBus[1];
  assign accept    = pulse_valid && run && !clear_now;
  assign dropped   = pulse_valid && !run && !clear_now;

  assign unused_bits = ^{OPB_seqAddr, OPB_BE[3:1], OPB_DBus[31:2]};

  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // A select still high across reset must drop once before it can be acked.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      state     <= IDLE;
      ack_q     <= 1'b0;
      sel_block <= OPB_select;
    end else begin
      if (!OPB_select) sel_block <= 1'b0;
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (hit && !sel_block) begin
            state <= ACK;
            ack_q <= 1'b1;
          end
        end
        ACK: begin
          state <= HOLD;
          ack_q <= 1'b0;
        end
        HOLD: begin
          ack_q <= 1'b0;
          if (!OPB_select) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) run <= 1'b0;
    else if (ctrl_wr) run <= OPB_DBus[0];
  end

  // Pulse stage: one registered cycle from accepted pulse to buffer write.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      wr_addr  <= '0;
      wrap     <= 1'b0;
      count    <= '0;
      drop     <= '0;
    end else begin
      buf_we <= accept;
      if (accept) begin
        buf_addr <= wr_addr;
        buf_data <= pulse_data;
      end
      if (clear_now) begin
        wr_addr <= '0;
        wrap    <= 1'b0;
        count   <= '0;
        drop    <= '0;
      end else begin
        if (accept) begin
          if (wr_addr == '1) wrap <= ~wrap;
          wr_addr <= wr_addr + 1'b1;
          count   <= count + 32'd1;
        end
        if (dropped) drop <= sat_inc(drop);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0: rdata = {31'd0, run};
      2'd1: rdata = {wrap, 31'(wr_addr)};
      2'd2: rdata = count;
      2'd3: rdata = drop;
      default: rdata = '0;
    endcase
  end

  assign Sl_DBus = ack_q ? rdata : 32'd0;

endmodule
